l15_core_req_transducer: RTL and testbench
==========================================

Name: l15_core_req_transducer

Overview:
- Sits directly upstream of the L1.5 wrapper.
- Converts a simple single-outstanding core memory port (valid/ready request, valid/ready response) into the L1.5 transducer protocol: it drives the transducer_l15_* request bundle and consumes the l15_transducer_* return bundle.
- Handles unsolicited returns (evictions, interrupts) by acknowledging and discarding them.
- Provides a watchdog that converts a lost return into an error response.

Parameters:
- TIMEOUT_CYCLES, 4096: cycles in WAIT_RET before an error response is forced; 0 disables the watchdog.
- NC_ADDR_BIT, 39: address bit that marks a request non-cacheable.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- core_req_val  in  1  core request valid
- core_req_rdy  out  1  block can accept a request
- core_req_we  in  1  1 = store, 0 = load
- core_req_addr  in  40  byte address
- core_req_size  in  3  000 = 1B, 001 = 2B, 010 = 4B, 011 = 8B
- core_req_wdata  in  64  store data, already lane-positioned
- core_rsp_val  out  1  response valid
- core_rsp_rdy  in  1  core accepts response
- core_rsp_rdata  out  64  load data (0 for stores)
- core_rsp_err  out  1  watchdog timeout or L1.5 error
- transducer_l15_val  out  1  request valid
- transducer_l15_rqtype  out  5  00000 LOAD_RQ, 00001 STORE_RQ
- transducer_l15_nc  out  1  equals addr[NC_ADDR_BIT]
- transducer_l15_size  out  3  latched size
- transducer_l15_address  out  40  latched address
- transducer_l15_data  out  64  latched wdata
- transducer_l15_threadid  out  1  constant 0
- l15_transducer_ack  in  1  request accepted
- l15_transducer_val  in  1  return valid
- l15_transducer_returntype  in  4  0000 LOAD_RET, 0100 ST_ACK, 0011 EVICT_REQ, 0111 INT_RET
- l15_transducer_error  in  2  nonzero = error
- l15_transducer_data_0  in  64  return word 0
- l15_transducer_data_1  in  64  return word 1
- transducer_l15_req_ack  out  1  return consumed
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, REQ, WAIT_RET, RESP.
- Reset values:
  - State = IDLE.
  - All outputs 0, except core_req_rdy = 1.
  - Watchdog counter = 0.
- Reset mid-operation abandons the in-flight request; no response is issued afterwards.
- IDLE:
  - core_req_rdy = 1.
  - On core_req_val, latch we/addr/size/wdata and go to REQ.
  - transducer_l15_val rises the cycle after acceptance.
- REQ:
  - transducer_l15_val = 1; the request fields hold stable until l15_transducer_ack.
  - On ack, go to WAIT_RET the next cycle and clear the counter.
  - The ack may arrive in the first REQ cycle.
- WAIT_RET:
  - The counter increments each cycle.
  - Matching return: LOAD_RET if latched we = 0, ST_ACK if latched we = 1.
  - On a matching return, in the same cycle:
    - transducer_l15_req_ack = 1.
    - rdata = addr[3] ? data_1 : data_0 for loads, 0 for stores.
    - err = |error.
    - Go to RESP.
  - If the counter reaches TIMEOUT_CYCLES − 1 with no match (TIMEOUT_CYCLES ≠ 0): err = 1, rdata = 0, go to RESP.
  - A late matching return after a timeout is acked and dropped.
- RESP:
  - core_rsp_val = 1; rdata and err hold until core_rsp_rdy.
  - Then go to IDLE; core_req_rdy = 1 again the following cycle.
  - No request/response bypass; minimum round trip is 4 cycles.
- Unsolicited returns:
  - Any l15_transducer_val with a non-matching returntype, or arriving in any state other than WAIT_RET, is acked combinationally the same cycle and discarded.
  - It causes no state change.
  - This covers EVICT_REQ, INT_RET, unknown codes, and stray returns.
- transducer_l15_req_ack is never asserted without l15_transducer_val and is high for exactly one cycle per return.
- A simultaneous unsolicited return and timeout in the same cycle: ack the return, take the timeout.
- The watchdog counter is wide enough for TIMEOUT_CYCLES and saturates; it never wraps.

Test Plan:
- Load: addr 0x00_0000_1008, size 011, L1.5 ack after 2 cycles, LOAD_RET with data_0 = 0x1111, data_1 = 0x2222 → core_rsp_rdata = 0x2222, err = 0, one req_ack pulse, nc = 0.
- Store: addr 0x80_0000_0000, wdata 0xDEADBEEF → rqtype 00001, nc = 1, request held stable through a 5-cycle ack delay; ST_ACK → rsp_val with rdata = 0, err = 0.
- EVICT_REQ injected during WAIT_RET, followed by LOAD_RET → EVICT acked the same cycle with state unchanged; load completes normally.
- Backpressure: core_rsp_rdy low for 10 cycles → rsp_val and rdata stable, core_req_rdy = 0 throughout, busy = 1.
- Timeout: TIMEOUT_CYCLES = 16, no return → rsp_val with err = 1 after 16 WAIT_RET cycles; a later LOAD_RET is acked and produces no response.
- Reset asserted in WAIT_RET → outputs return to reset values immediately; a new request after reset completes correctly.

Source files
------------

// File: rtl/l15_core_req_transducer.sv
// Bridges a single-outstanding core memory port onto the L1.5 transducer interface.
// Unsolicited returns are acked and dropped; a watchdog turns a lost return into an error response.
module l15_core_req_transducer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int NC_ADDR_BIT    = 39
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req_val,
  output logic        core_req_rdy,
  input  logic        core_req_we,
  input  logic [39:0] core_req_addr,
  input  logic [2:0]  core_req_size,
  input  logic [63:0] core_req_wdata,
  output logic        core_rsp_val,
  input  logic        core_rsp_rdy,
  output logic [63:0] core_rsp_rdata,
  output logic        core_rsp_err,
  output logic        transducer_l15_val,
  output logic [4:0]  transducer_l15_rqtype,
  output logic        transducer_l15_nc,
  output logic [2:0]  transducer_l15_size,
  output logic [39:0] transducer_l15_address,
  output logic [63:0] transducer_l15_data,
  output logic        transducer_l15_threadid,
  input  logic        l15_transducer_ack,
  input  logic        l15_transducer_val,
  input  logic [3:0]  l15_transducer_returntype,
  input  logic [1:0]  l15_transducer_error,
  input  logic [63:0] l15_transducer_data_0,
  input  logic [63:0] l15_transducer_data_1,
  output logic        transducer_l15_req_ack,
  output logic        busy
);

  localparam int CNT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];
  localparam logic WD_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [3:0] RT_LOAD_RET = 4'b0000;
  localparam logic [3:0] RT_ST_ACK   = 4'b0100;
  localparam logic [4:0] RQ_LOAD     = 5'b00000;
  localparam logic [4:0] RQ_STORE    = 5'b00001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RET,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_we;
  logic [39:0]       r_addr;
  logic [2:0]        r_size;
  logic [63:0]       r_wdata;
  logic [63:0]       r_rdata;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_latch;
  logic              w_rsp_load;
  logic [63:0]       w_rsp_rdata;
  logic              w_rsp_err;
  logic              w_match;
  logic [3:0]        w_expect_rt;

  assign w_expect_rt = r_we ? RT_ST_ACK : RT_LOAD_RET;
  assign w_match     = (r_state == S_WAIT_RET) && l15_transducer_val &&
                       (l15_transducer_returntype == w_expect_rt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    w_rsp_load   = 1'b0;
    w_rsp_rdata  = '0;
    w_rsp_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (core_req_val) begin
          w_latch      = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (l15_transducer_ack) begin
          w_cnt_next   = '0;
          w_state_next = S_WAIT_RET;
        end
      end
      S_WAIT_RET: begin
        if (r_cnt != '1) begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
        // A matching return wins over a timeout landing in the same cycle.
        if (w_match) begin
          w_rsp_load   = 1'b1;
          w_rsp_rdata  = r_we ? 64'd0 :
                         (r_addr[3] ? l15_transducer_data_1 : l15_transducer_data_0);
          w_rsp_err    = |l15_transducer_error;
          w_state_next = S_RESP;
        end else if (WD_EN && (r_cnt == TO_LAST)) begin
          w_rsp_load   = 1'b1;
          w_rsp_rdata  = '0;
          w_rsp_err    = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (core_rsp_rdy) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_latch) begin
        r_we    <= core_req_we;
        r_addr  <= core_req_addr;
        r_size  <= core_req_size;
        r_wdata <= core_req_wdata;
      end
      if (w_rsp_load) begin
        r_rdata <= w_rsp_rdata;
        r_err   <= w_rsp_err;
      end
    end
  end

  assign core_req_rdy            = (r_state == S_IDLE);
  assign busy                    = (r_state != S_IDLE);
  assign core_rsp_val            = (r_state == S_RESP);
  assign core_rsp_rdata          = r_rdata;
  assign core_rsp_err            = r_err;
  assign transducer_l15_val      = (r_state == S_REQ);
  assign transducer_l15_rqtype   = r_we ? RQ_STORE : RQ_LOAD;
  assign transducer_l15_nc       = r_addr[NC_ADDR_BIT];
  assign transducer_l15_size     = r_size;
  assign transducer_l15_address  = r_addr;
  assign transducer_l15_data     = r_wdata;
  assign transducer_l15_threadid = 1'b0;
  // Every return, matching or not, is consumed in the cycle it is presented.
  assign transducer_l15_req_ack  = l15_transducer_val;

endmodule

// File: tb/tb_l15_core_req_transducer.sv
// Directed and randomized checks of l15_core_req_transducer against a transaction-level model.
module tb_l15_core_req_transducer;

  localparam int TO = 16;
  localparam logic [3:0] RT_LOAD  = 4'b0000;
  localparam logic [3:0] RT_STACK = 4'b0100;
  localparam logic [3:0] RT_EVICT = 4'b0011;
  localparam logic [3:0] RT_INT   = 4'b0111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        core_req_val, core_req_rdy, core_req_we;
  logic [39:0] core_req_addr;
  logic [2:0]  core_req_size;
  logic [63:0] core_req_wdata;
  logic        core_rsp_val, core_rsp_rdy, core_rsp_err;
  logic [63:0] core_rsp_rdata;
  logic        transducer_l15_val, transducer_l15_nc, transducer_l15_threadid;
  logic [4:0]  transducer_l15_rqtype;
  logic [2:0]  transducer_l15_size;
  logic [39:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic        l15_transducer_ack, l15_transducer_val;
  logic [3:0]  l15_transducer_returntype;
  logic [1:0]  l15_transducer_error;
  logic [63:0] l15_transducer_data_0, l15_transducer_data_1;
  logic        transducer_l15_req_ack, busy;

  l15_core_req_transducer #(.TIMEOUT_CYCLES(TO), .NC_ADDR_BIT(39)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_val(core_req_val), .core_req_rdy(core_req_rdy), .core_req_we(core_req_we),
    .core_req_addr(core_req_addr), .core_req_size(core_req_size), .core_req_wdata(core_req_wdata),
    .core_rsp_val(core_rsp_val), .core_rsp_rdy(core_rsp_rdy),
    .core_rsp_rdata(core_rsp_rdata), .core_rsp_err(core_rsp_err),
    .transducer_l15_val(transducer_l15_val), .transducer_l15_rqtype(transducer_l15_rqtype),
    .transducer_l15_nc(transducer_l15_nc), .transducer_l15_size(transducer_l15_size),
    .transducer_l15_address(transducer_l15_address), .transducer_l15_data(transducer_l15_data),
    .transducer_l15_threadid(transducer_l15_threadid),
    .l15_transducer_ack(l15_transducer_ack), .l15_transducer_val(l15_transducer_val),
    .l15_transducer_returntype(l15_transducer_returntype),
    .l15_transducer_error(l15_transducer_error),
    .l15_transducer_data_0(l15_transducer_data_0), .l15_transducer_data_1(l15_transducer_data_1),
    .transducer_l15_req_ack(transducer_l15_req_ack), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  int ack_pulses = 0;
  int ack_orphans = 0;
  int txn_no = 0;

  logic        exp_we;
  logic [39:0] exp_addr;
  logic [2:0]  exp_size;
  logic [63:0] exp_wdata;

  always @(posedge clk) begin
    if (transducer_l15_req_ack) ack_pulses <= ack_pulses + 1;
    if (transducer_l15_req_ack && !l15_transducer_val) ack_orphans <= ack_orphans + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: what the core must receive for a completed return.
  function automatic logic [63:0] model_rdata(input logic we, input logic [39:0] addr,
                                              input logic [63:0] d0, input logic [63:0] d1);
    if (we) return 64'd0;
    return addr[3] ? d1 : d0;
  endfunction

  function automatic logic [49:0] req_view_expected();
    return {1'b1, (exp_we ? 5'd1 : 5'd0), exp_addr[39], exp_size, exp_addr};
  endfunction

  function automatic logic [49:0] req_view_actual();
    return {transducer_l15_val, transducer_l15_rqtype, transducer_l15_nc,
            transducer_l15_size, transducer_l15_address};
  endfunction

  task automatic issue(input logic we, input logic [39:0] addr, input logic [2:0] size,
                       input logic [63:0] wdata);
    logic [63:0] junk;
    chk("idle_req_rdy", core_req_rdy, 1);
    exp_we = we; exp_addr = addr; exp_size = size; exp_wdata = wdata;
    core_req_val = 1'b1; core_req_we = we; core_req_addr = addr;
    core_req_size = size; core_req_wdata = wdata;
    @(negedge clk);
    junk = {$urandom, $urandom};
    core_req_val = 1'b0; core_req_we = ~we; core_req_addr = junk[39:0];
    core_req_size = junk[42:40]; core_req_wdata = ~junk;
    chk("req_fields", req_view_actual(), req_view_expected());
    chk("req_data", transducer_l15_data, exp_wdata);
    chk("req_busy_rdy", {busy, core_req_rdy, transducer_l15_threadid}, 3'b100);
  endtask

  task automatic l15_accept(input int delay);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("req_hold", req_view_actual(), req_view_expected());
      chk("req_hold_data", transducer_l15_data, exp_wdata);
    end
    l15_transducer_ack = 1'b1;
    @(negedge clk);
    l15_transducer_ack = 1'b0;
    chk("after_ack_l15_val", {transducer_l15_val, busy}, 2'b01);
  endtask

  task automatic present_ret(input logic [3:0] rt, input logic [63:0] d0, input logic [63:0] d1,
                             input logic [1:0] e);
    l15_transducer_val = 1'b1; l15_transducer_returntype = rt;
    l15_transducer_data_0 = d0; l15_transducer_data_1 = d1; l15_transducer_error = e;
    #1;
    chk("ret_req_ack", transducer_l15_req_ack, 1);
    @(negedge clk);
    l15_transducer_val = 1'b0;
    l15_transducer_returntype = 4'hF;
    l15_transducer_data_0 = '0; l15_transducer_data_1 = '0; l15_transducer_error = '0;
  endtask

  task automatic take_resp(input logic [63:0] rdata, input logic err, input int hold);
    chk("rsp_val", core_rsp_val, 1);
    chk("rsp_rdata", core_rsp_rdata, rdata);
    chk("rsp_err", core_rsp_err, err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold", {core_rsp_val, core_rsp_err, core_req_rdy, busy}, {1'b1, err, 1'b0, 1'b1});
      chk("rsp_hold_rdata", core_rsp_rdata, rdata);
    end
    core_rsp_rdy = 1'b1;
    @(negedge clk);
    core_rsp_rdy = 1'b0;
    chk("back_to_idle", {core_rsp_val, core_req_rdy, busy}, 3'b010);
  endtask

  task automatic run_txn(input logic we, input logic [39:0] addr, input logic [2:0] size,
                         input logic [63:0] wdata, input int ackd, input int retd,
                         input logic stray, input logic [3:0] stray_rt,
                         input logic [63:0] d0, input logic [63:0] d1, input logic [1:0] e,
                         input int hold);
    int base;
    logic [63:0] want;
    issue(we, addr, size, wdata);
    l15_accept(ackd);
    base = ack_pulses;
    if (stray) begin
      present_ret(stray_rt, ~d0, ~d1, 2'b00);
      chk("stray_no_change", {core_rsp_val, busy, transducer_l15_val}, 3'b010);
    end
    for (int i = 0; i < retd; i++) begin
      @(negedge clk);
      chk("wait_no_rsp", core_rsp_val, 0);
    end
    present_ret(we ? RT_STACK : RT_LOAD, d0, d1, e);
    want = model_rdata(we, addr, d0, d1);
    take_resp(want, |e, hold);
    chk("req_ack_pulses", ack_pulses - base, stray ? 2 : 1);
    $display("txn %0d we=%0d addr=%h size=%0d stray=%0d rdata=%h err=%0d",
             txn_no, we, addr, size, stray, want, |e);
    txn_no++;
  endtask

  initial begin
    logic [63:0] r64;
    logic [3:0]  srt;
    int cyc;

    rst_n = 1'b0;
    core_req_val = 0; core_req_we = 0; core_req_addr = '0; core_req_size = '0;
    core_req_wdata = '0; core_rsp_rdy = 0;
    l15_transducer_ack = 0; l15_transducer_val = 0; l15_transducer_returntype = 4'hF;
    l15_transducer_error = '0; l15_transducer_data_0 = '0; l15_transducer_data_1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {core_req_rdy, busy, core_rsp_val, core_rsp_err, transducer_l15_val,
                       transducer_l15_nc, transducer_l15_req_ack}, 7'b1000000);
    chk("reset_fields", {transducer_l15_rqtype, transducer_l15_size, transducer_l15_address},
        48'd0);
    chk("reset_data", transducer_l15_data | core_rsp_rdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Load hitting the upper word, L1.5 acks after 2 cycles
    run_txn(1'b0, 40'h00_0000_1008, 3'b011, 64'h0, 2, 1, 1'b0, RT_EVICT,
            64'h1111, 64'h2222, 2'b00, 0);
    // Non-cacheable store held through a 5-cycle ack delay
    run_txn(1'b1, 40'h80_0000_0000, 3'b010, 64'hDEAD_BEEF, 5, 2, 1'b0, RT_EVICT,
            64'h5555, 64'h6666, 2'b00, 0);
    // Eviction arriving while waiting, then the load completes
    run_txn(1'b0, 40'h00_0000_2000, 3'b011, 64'h0, 0, 0, 1'b1, RT_EVICT,
            64'hABCD, 64'h1234, 2'b00, 0);
    // Wrong-type return while waiting must not complete the load
    run_txn(1'b0, 40'h00_0000_3000, 3'b001, 64'h0, 1, 1, 1'b1, RT_STACK,
            64'h77, 64'h88, 2'b01, 1);
    // Response backpressure for 10 cycles
    run_txn(1'b0, 40'h00_0000_4008, 3'b011, 64'h0, 0, 3, 1'b0, RT_EVICT,
            64'hCAFE, 64'hF00D, 2'b00, 10);

    // Stray return while idle
    present_ret(RT_INT, 64'h1, 64'h2, 2'b00);
    chk("idle_stray", {busy, core_rsp_val, core_req_rdy}, 3'b001);

    for (int n = 0; n < 24; n++) begin
      r64 = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0: srt = RT_EVICT;
        1: srt = RT_INT;
        default: srt = 4'hA;
      endcase
      run_txn(1'($urandom_range(0, 1)), r64[39:0], 3'($urandom_range(0, 3)),
              {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 6),
              ($urandom_range(0, 2) == 0), srt, {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              $urandom_range(0, 3));
    end

    // Watchdog: no return; an eviction lands on the timeout cycle
    issue(1'b0, 40'h00_1234_5000, 3'b011, 64'h0);
    l15_accept(0);
    cyc = 0;
    while (!core_rsp_val && cyc < 40) begin
      if (cyc == TO - 1) begin
        l15_transducer_val = 1'b1; l15_transducer_returntype = RT_EVICT;
        #1;
        chk("evict_at_timeout_ack", transducer_l15_req_ack, 1);
      end
      @(negedge clk);
      l15_transducer_val = 1'b0;
      cyc++;
    end
    chk("timeout_wait_cycles", cyc, TO);
    take_resp(64'd0, 1'b1, 0);
    $display("txn %0d timeout after %0d wait cycles", txn_no, cyc);
    txn_no++;
    present_ret(RT_LOAD, 64'h99, 64'h98, 2'b00);
    repeat (3) begin
      chk("late_ret_dropped", {core_rsp_val, busy}, 2'b00);
      @(negedge clk);
    end

    // Reset while waiting for a return
    issue(1'b1, 40'h80_0000_0040, 3'b011, 64'h1234_5678);
    l15_accept(1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", {core_req_rdy, busy, core_rsp_val, transducer_l15_val,
                          transducer_l15_nc}, 5'b10000);
    chk("midreset_fields", {transducer_l15_rqtype, transducer_l15_address}, 45'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    present_ret(RT_STACK, 64'h0, 64'h0, 2'b00);
    chk("post_reset_no_rsp", {core_rsp_val, busy}, 2'b00);
    $display("txn %0d reset abandoned store", txn_no);
    txn_no++;
    run_txn(1'b0, 40'h00_0000_5000, 3'b011, 64'h0, 1, 1, 1'b0, RT_EVICT,
            64'h4242, 64'h2424, 2'b00, 0);

    chk("ack_without_val", ack_orphans, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
